// File: rtl/ddr_bw_pkg.sv
// Shared types and constants for the DDR bandwidth test controller.
package ddr_bw_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_IDLE = 3'd3,
        NEXT      = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam int BURST_LENGTH_DFLT = 7;
    localparam int BEATS_PER_BURST   = BURST_LENGTH_DFLT + 1;

    localparam int ERR_CFG     = 0;
    localparam int ERR_TIMEOUT = 1;

    function automatic int beats_per_burst(input int burst_length);
        return burst_length + 1;
    endfunction

endpackage

// File: rtl/ddr_bw_pattern_gen.sv
// Counting-pattern AXIS source: beat index tagged with the pass number,
// tlast on the final beat of every burst. Arm loads a beat budget, flush drops it.
module ddr_bw_pattern_gen
    import ddr_bw_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = BURST_LENGTH_DFLT,
    parameter int CNT_W        = 36
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm_i,
    input  logic [CNT_W-1:0]      arm_beats_i,
    input  logic [15:0]           arm_pass_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic                  tlast_o
);

    localparam int BW = DATA_WIDTH - 16;
    localparam int PW = $clog2(BURST_LENGTH + 2);
    localparam logic [PW-1:0] LAST_POS = PW'(BURST_LENGTH);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [15:0]      tag_q, tag_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             fire;

    assign tvalid_o = (rem_q != '0);
    assign fire     = tvalid_o & tready_i;
    assign tdata_o  = {tag_q, beat_q};
    assign tlast_o  = tvalid_o && (pos_q == LAST_POS);

    always_comb begin
        rem_d  = rem_q;
        beat_d = beat_q;
        tag_d  = tag_q;
        pos_d  = pos_q;
        // Arm wins over flush so a pass can be discarded and re-armed in one step.
        if (arm_i) begin
            rem_d  = arm_beats_i;
            beat_d = '0;
            tag_d  = arm_pass_i;
            pos_d  = '0;
        end else if (flush_i) begin
            rem_d = '0;
        end else if (fire) begin
            rem_d  = rem_q - 1'b1;
            beat_d = beat_q + 1'b1;
            pos_d  = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q  <= '0;
            beat_q <= '0;
            tag_q  <= '0;
            pos_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            beat_q <= beat_d;
            tag_q  <= tag_d;
            pos_q  <= pos_d;
        end
    end

endmodule

// File: rtl/ddr_bw_test_ctrl.sv
// Sequencer for DDR bandwidth runs: NREP passes of NBURST bursts, stride per pass.
// Optional per-pass watchdog compiled in with DDR_BW_CTRL_TIMEOUT_EN.
module ddr_bw_test_ctrl
    import ddr_bw_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LENGTH   = BURST_LENGTH_DFLT,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_start,
    input  logic [31:0]           cfg_addr,
    input  logic [31:0]           cfg_nburst,
    input  logic [15:0]           cfg_nrep,
    input  logic [31:0]           cfg_stride,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [1:0]            sts_err,
    output logic [31:0]           sts_cycles,
    output logic [15:0]           sts_pass,
    output logic                  mst_start,
    output logic [31:0]           mst_addr,
    output logic [31:0]           mst_nburst,
    input  logic                  mst_idle,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [2:0]            dbg_state_o
);

    localparam int BEATS = beats_per_burst(BURST_LENGTH);
    localparam int CNT_W = 32 + $clog2(BEATS + 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] nburst_q, nburst_d;
    logic [15:0] nrep_q, nrep_d;
    logic [31:0] stride_q, stride_d;
    logic [15:0] pass_q, pass_d;
    logic [31:0] cycles_q, cycles_d;
    logic        cfg_err_q, cfg_err_d;
    logic        arm, flush, tmo_hit;
    logic [CNT_W-1:0] arm_beats;

    assign sts_busy    = (state_q == CHECK) || (state_q == LAUNCH) ||
                         (state_q == WAIT_IDLE) || (state_q == NEXT);
    assign sts_done    = (state_q == DONE);
    assign mst_start   = (state_q == LAUNCH);
    assign sts_cycles  = cycles_q;
    assign sts_pass    = pass_q;
    assign mst_addr    = addr_q;
    assign mst_nburst  = nburst_q;
    assign dbg_state_o = state_q;
    assign arm_beats   = CNT_W'(nburst_d) * CNT_W'(BEATS);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nburst_d  = nburst_q;
        nrep_d    = nrep_q;
        stride_d  = stride_q;
        pass_d    = pass_q;
        cycles_d  = cycles_q;
        cfg_err_d = cfg_err_q;
        arm       = 1'b0;
        flush     = 1'b0;
        if ((state_q == LAUNCH || state_q == WAIT_IDLE || state_q == NEXT) &&
            cycles_q != 32'hFFFF_FFFF)
            cycles_d = cycles_q + 32'd1;
        case (state_q)
            IDLE: if (cfg_start) state_d = CHECK;
            CHECK: begin
                nrep_d    = cfg_nrep;
                stride_d  = cfg_stride;
                pass_d    = '0;
                cycles_d  = '0;
                cfg_err_d = 1'b0;
                if (cfg_nburst == '0 || cfg_nrep == '0) begin
                    cfg_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    addr_d   = cfg_addr;
                    nburst_d = cfg_nburst;
                    arm      = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH:    if (!mst_idle) state_d = WAIT_IDLE;
            // Idle must be seen low first, so a master still finishing cannot fake completion.
            WAIT_IDLE: if (mst_idle) state_d = NEXT;
            NEXT: begin
                pass_d = pass_q + 16'd1;
                flush  = 1'b1;
                if (pass_d == nrep_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + stride_q;
                    arm     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            DONE:    if (!cfg_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            flush   = 1'b1;
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            nburst_q  <= '0;
            nrep_q    <= '0;
            stride_q  <= '0;
            pass_q    <= '0;
            cycles_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nburst_q  <= nburst_d;
            nrep_q    <= nrep_d;
            stride_q  <= stride_d;
            pass_q    <= pass_d;
            cycles_q  <= cycles_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef DDR_BW_CTRL_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] tmo_q, tmo_d;
    logic        tmo_err_q, tmo_err_d;

    always_comb begin
        tmo_d     = '0;
        tmo_err_d = tmo_err_q;
        tmo_hit   = 1'b0;
        if (state_q == CHECK) tmo_err_d = 1'b0;
        if (state_q == LAUNCH || state_q == WAIT_IDLE) begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_q == TMO_LAST) begin
                tmo_hit   = 1'b1;
                tmo_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign sts_err = {tmo_err_q, cfg_err_q};
`else
    // Watchdog not built: the limit is irrelevant and this folds to constant 0.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
    assign sts_err = {1'b0, cfg_err_q};
`endif

    ddr_bw_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BURST_LENGTH(BURST_LENGTH),
        .CNT_W       (CNT_W)
    ) u_pattern_gen (
        .clk        (clk),
        .rstn       (rstn),
        .arm_i      (arm),
        .arm_beats_i(arm_beats),
        .arm_pass_i (pass_d),
        .flush_i    (flush),
        .tdata_o    (m_axis_tdata),
        .tvalid_o   (m_axis_tvalid),
        .tready_i   (m_axis_tready),
        .tlast_o    (m_axis_tlast)
    );

endmodule
